// File: rtl/wave_capture_ctrl.sv
// -----------------------------------------------------------------------------
// wave_capture_ctrl
//
// Double-buffer write scheduler for the 512x8 waveform sample RAM.
//
// ARMED waits for a positive zero-crossing (previous sample negative, current
// sample non-negative). ACTIVE then writes CAPTURE_LEN samples into the RAM
// half the display is not reading. WAIT holds the finished half back until
// the display is blanking, and only then flips read_index. A displayed frame
// therefore never mixes two captures.
//
// Optional feature, macro WAVE_TRIGGER_TIMEOUT_EN:
//   When defined, ARMED counts strobes since it was entered. The
//   TRIG_TIMEOUT-th strobe without a trigger forces a capture, so a flat or DC
//   input still refreshes the display. When undefined, ARMED waits
//   indefinitely and no timeout counter is built.
//
// Clocking and reset: every register updates on the rising edge of clk.
// reset is synchronous and active-low.
// -----------------------------------------------------------------------------
module wave_capture_ctrl #(
  parameter int SAMPLE_W     = 16,
  parameter int CAPTURE_LEN  = 256,  // must equal 2**(ADDR_W-1)
  parameter int ADDR_W       = 9,
  parameter int TRIG_TIMEOUT = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [ADDR_W-1:0]   write_address,
  output logic [7:0]          write_sample,
  output logic                write_enable,
  output logic                read_index
);

  localparam int CNT_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CAPTURE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic signed [SAMPLE_W-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    count, count_n;
  logic                read_index_n;
  logic                write_enable_n;
  logic [ADDR_W-1:0]   write_address_n;
  logic [7:0]          write_sample_n;
  logic [SAMPLE_W-1:0] prev_sample;

  // Display byte: signed sample top byte moved to offset-binary (+128).
  logic [7:0] sample_byte;
  assign sample_byte = new_sample_in[SAMPLE_W-1 -: 8] ^ 8'h80;

  // Positive zero-crossing between the previous strobe and this one.
  logic crossing;
  assign crossing = ($signed(prev_sample) < ZERO) && ($signed(new_sample_in) >= ZERO);

`ifdef WAVE_TRIGGER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TRIG_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TRIG_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_count, tmo_count_n;
  logic             timeout_hit;

  // The strobe that would be the TRIG_TIMEOUT-th one seen in ARMED.
  assign timeout_hit = new_sample_ready && (tmo_count == TMO_LAST);
`else
  // Without the timeout feature the limit has no hardware behind it.
  localparam int unused_trig_timeout = TRIG_TIMEOUT;
  logic timeout_hit;
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output decode for the capture FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_n         = state;
    count_n         = count;
    read_index_n    = read_index;
    write_enable_n  = 1'b0;
    write_address_n = write_address;
    write_sample_n  = write_sample;
`ifdef WAVE_TRIGGER_TIMEOUT_EN
    tmo_count_n     = '0;
`endif

    unique case (state)
      S_ARMED: begin
`ifdef WAVE_TRIGGER_TIMEOUT_EN
        if (new_sample_ready) tmo_count_n = tmo_count + 1'b1;
        else                  tmo_count_n = tmo_count;
`endif
        if (new_sample_ready && (crossing || timeout_hit)) begin
          // The trigger sample itself is the first sample of the capture.
          write_enable_n  = 1'b1;
          write_address_n = {~read_index, {CNT_W{1'b0}}};
          write_sample_n  = sample_byte;
          count_n         = CNT_ONE;
          state_n         = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (new_sample_ready) begin
          write_enable_n  = 1'b1;
          write_address_n = {~read_index, count};
          write_sample_n  = sample_byte;
          if (count == CNT_LAST) begin
            count_n = '0;
            state_n = S_WAIT;
          end else begin
            count_n = count + 1'b1;
          end
        end
      end

      S_WAIT: begin
        // Strobes are dropped here; hand over the new half only during blanking.
        if (wave_display_idle) begin
          read_index_n = ~read_index;
          state_n      = S_ARMED;
        end
      end

      default: begin
        state_n = S_ARMED;
        count_n = '0;
      end
    endcase
  end

  // State, counters and all outputs are registered; synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state         <= S_ARMED;
      count         <= '0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
      prev_sample   <= '0;
`ifdef WAVE_TRIGGER_TIMEOUT_EN
      tmo_count     <= '0;
`endif
    end else begin
      state         <= state_n;
      count         <= count_n;
      read_index    <= read_index_n;
      write_enable  <= write_enable_n;
      write_address <= write_address_n;
      write_sample  <= write_sample_n;
      if (new_sample_ready) prev_sample <= new_sample_in;
`ifdef WAVE_TRIGGER_TIMEOUT_EN
      tmo_count     <= tmo_count_n;
`endif
    end
  end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wave_capture_ctrl
//
// Directed bench for wave_capture_ctrl. Every strobe that should write pushes
// its {address, byte} onto a scoreboard queue. A negedge monitor pops one
// entry per write_enable pulse and flags any pulse nobody expected.
// -----------------------------------------------------------------------------
module tb_wave_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic [7:0]  write_sample;
  logic        write_enable;
  logic        read_index;

  wave_capture_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_sample      (write_sample),
    .write_enable      (write_enable),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] smp;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  passed   = 0;
  int  wr_count = 0;
  bit  mon_on   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the edge.
  task automatic tick(input logic rdy, input logic [15:0] s);
    new_sample_ready = rdy;
    new_sample_in    = s;
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
  endtask

  task automatic expect_wr(input logic [8:0] a, input logic [7:0] b);
    exp_q.push_back('{addr: a, smp: b});
  endtask

  // Scoreboard consumer: each write pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_on && write_enable === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {23'd0, write_address}, 32'h1FF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {23'd0, write_address}, {23'd0, e.addr});
        chk("wr_sample", {24'd0, write_sample}, {24'd0, e.smp});
      end
    end
  end

  initial begin
    reset             = 1'b0;
    new_sample_ready  = 1'b0;
    new_sample_in     = '0;
    wave_display_idle = 1'b0;

    // Reset held three cycles: all outputs cleared.
    repeat (3) tick(1'b0, 16'h0000);
    chk("rst_we",   {31'd0, write_enable}, 32'd0);
    chk("rst_addr", {23'd0, write_address}, 32'd0);
    chk("rst_smp",  {24'd0, write_sample}, 32'd0);
    chk("rst_ri",   {31'd0, read_index}, 32'd0);
    reset  = 1'b1;
    mon_on = 1'b1;

    // Monotonic positive input never triggers; idle is ignored in ARMED.
    wave_display_idle = 1'b1;
    repeat (5) tick(1'b1, 16'h1000);
    chk("armed_idle_ri", {31'd0, read_index}, 32'd0);
    wave_display_idle = 1'b0;
    chk("armed_no_write", wr_count, 0);

    // Crossing FF00 -> 1234, then 255 back-to-back strobes fill half 1.
    wr_count = 0;
    tick(1'b1, 16'hFF00);
    expect_wr(9'h100, 8'h92);
    tick(1'b1, 16'h1234);
    for (int i = 1; i < 256; i++) begin
      logic [7:0] hi;
      hi = 8'(i);
      expect_wr(9'h100 + 9'(i), hi ^ 8'h80);
      tick(1'b1, {hi, 8'h5A});
    end
    tick(1'b0, 16'h0000);
    chk("cap1_pulses", wr_count, 256);
    chk("cap1_drain", exp_q.size(), 0);
    chk("cap1_ri", {31'd0, read_index}, 32'd0);

    // WAIT: strobes (even crossings) are dropped.
    wr_count = 0;
    for (int i = 0; i < 10; i++) tick(1'b1, (i % 2 == 0) ? 16'hFF00 : 16'h0100);
    tick(1'b0, 16'h0000);
    chk("wait_no_write", wr_count, 0);
    chk("wait_ri_hold", {31'd0, read_index}, 32'd0);

    // Strobe and idle in the same WAIT cycle: strobe dropped, half flips.
    wave_display_idle = 1'b1;
    tick(1'b1, 16'hFF00);
    wave_display_idle = 1'b0;
    chk("flip_ri", {31'd0, read_index}, 32'd1);
    tick(1'b0, 16'h0000);
    chk("flip_no_write", write_enable, 0);

    // prev_sample kept FF00 from the dropped strobe, so 0100 is a crossing.
    // Spaced strobes fill half 0.
    wr_count = 0;
    expect_wr(9'h000, 8'h81);
    tick(1'b1, 16'h0100);
    for (int i = 1; i < 256; i++) begin
      logic [7:0] hi;
      hi = 8'(255 - i);
      expect_wr(9'(i), hi ^ 8'h80);
      tick(1'b1, {hi, 8'h00});
      tick(1'b0, 16'h0000);
    end
    tick(1'b0, 16'h0000);
    chk("cap2_pulses", wr_count, 256);
    chk("cap2_drain", exp_q.size(), 0);
    wave_display_idle = 1'b1;
    tick(1'b0, 16'h0000);
    wave_display_idle = 1'b0;
    chk("flip_back_ri", {31'd0, read_index}, 32'd0);

    // Reset mid-capture after 10 writes.
    tick(1'b1, 16'h8000);
    expect_wr(9'h100, 8'h80);
    tick(1'b1, 16'h0000);
    for (int i = 1; i < 10; i++) begin
      expect_wr(9'h100 + 9'(i), 8'h83);
      tick(1'b1, 16'h0300);
    end
    reset = 1'b0;
    tick(1'b0, 16'h0000);
    reset = 1'b1;
    chk("abort_we", {31'd0, write_enable}, 32'd0);
    chk("abort_ri", {31'd0, read_index}, 32'd0);
    chk("abort_drain", exp_q.size(), 0);
    wr_count = 0;
    tick(1'b1, 16'h0100);
    tick(1'b0, 16'h0000);
    chk("abort_no_write", wr_count, 0);
    tick(1'b1, 16'hFF00);
    expect_wr(9'h100, 8'h81);
    tick(1'b1, 16'h0100);
    tick(1'b0, 16'h0000);
    chk("rearm_drain", exp_q.size(), 0);

    // Flat DC input from a fresh reset.
    reset = 1'b0;
    tick(1'b0, 16'h0000);
    reset = 1'b1;
    wr_count = 0;
`ifdef WAVE_TRIGGER_TIMEOUT_EN
    repeat (511) tick(1'b1, 16'h0100);
    tick(1'b0, 16'h0000);
    chk("tmo_pre_write", wr_count, 0);
    expect_wr(9'h100, 8'h81);
    tick(1'b1, 16'h0100);
    tick(1'b0, 16'h0000);
    chk("tmo_write", wr_count, 1);
    chk("tmo_drain", exp_q.size(), 0);
`else
    repeat (1000) tick(1'b1, 16'h0100);
    tick(1'b0, 16'h0000);
    chk("dc_no_write", wr_count, 0);
    chk("dc_drain", exp_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
